// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage plus IF/ID pipeline register for the RV64I core.
//   Sequences the PC, drives a single-outstanding req/gnt/rvalid instruction
//   memory port, and holds, bubbles or flushes IF/ID according to the
//   load-use stall and the EX-stage redirect.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   stall             load-use stall: hold IF/ID
//   redirect          taken branch/jump from EX: flush IF/ID and refetch
//   redirect_pc       refetch target, valid with redirect
//   imem_req/addr     fetch request and address
//   imem_gnt          request accepted this cycle
//   imem_rvalid/rdata fetched instruction response
//   Inst_id/Pc_id     IF/ID instruction and its PC
//   Valid_id          IF/ID holds a real instruction (0 = bubble)
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     Inst_id,
    output logic [XLEN-1:0] Pc_id,
    output logic            Valid_id
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_BUF} state_e;

    state_e          state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_inflight_q;
    logic [31:0]     buf_inst_q;
    logic [XLEN-1:0] buf_pc_q;
    logic            drop_q;

    logic            rsp_ok;
    logic            deliver;
    logic [31:0]     dlv_inst;
    logic [XLEN-1:0] dlv_pc;
    logic [XLEN-1:0] pc_d;

    // A redirect suppresses the request for its cycle so the old address is
    // never granted after the branch resolved.
    assign imem_req  = rst_n && (state_q == S_REQ) && !redirect;
    assign imem_addr = pc_q;

    // Response that is allowed to reach IF/ID (not marked stale, not flushed).
    assign rsp_ok  = (state_q == S_WAIT) && imem_rvalid && !drop_q && !redirect;
    assign deliver = !redirect && !stall && (rsp_ok || (state_q == S_BUF));
    assign dlv_inst = (state_q == S_BUF) ? buf_inst_q : imem_rdata;
    assign dlv_pc   = (state_q == S_BUF) ? buf_pc_q   : pc_inflight_q;

    // Sequential PC increment wraps naturally modulo 2^XLEN.
    assign pc_d = pc_q + XLEN'(4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            pc_inflight_q <= '0;
            buf_inst_q    <= NOP;
            buf_pc_q      <= '0;
            drop_q        <= 1'b0;
            Valid_id      <= 1'b0;
            Inst_id       <= NOP;
            Pc_id         <= '0;
        end else begin
            // Any redirect retargets the PC regardless of state.
            if (redirect) pc_q <= redirect_pc;

            unique case (state_q)
                S_REQ: begin
                    if (!redirect && imem_gnt) begin
                        pc_inflight_q <= pc_q;
                        pc_q          <= pc_d;
                        state_q       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (drop_q || redirect) begin
                            // Stale response: discard. A redirect arriving
                            // with the response needs no further drop.
                            drop_q  <= 1'b0;
                            state_q <= S_REQ;
                        end else if (stall) begin
                            buf_inst_q <= imem_rdata;
                            buf_pc_q   <= pc_inflight_q;
                            state_q    <= S_BUF;
                        end else begin
                            state_q <= S_REQ;
                        end
                    end else if (redirect) begin
                        // Outstanding request now belongs to the wrong path.
                        drop_q <= 1'b1;
                    end
                end
                S_BUF: begin
                    if (redirect || !stall) state_q <= S_REQ;
                end
                default: state_q <= S_REQ;
            endcase

            // IF/ID register: redirect > stall > deliver > bubble.
            if (redirect) begin
                Valid_id <= 1'b0;
                Inst_id  <= NOP;
                Pc_id    <= '0;
            end else if (!stall) begin
                if (deliver) begin
                    Valid_id <= 1'b1;
                    Inst_id  <= dlv_inst;
                    Pc_id    <= dlv_pc;
                end else begin
                    Valid_id <= 1'b0;
                    Inst_id  <= NOP;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [31:0] N = 32'h0000_0013;
    localparam logic [63:0] B = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, redirect;
    logic [63:0] redirect_pc;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt, imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] Inst_id;
    logic [63:0] Pc_id;
    logic        Valid_id;

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .Inst_id(Inst_id), .Pc_id(Pc_id), .Valid_id(Valid_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st, rd;
        logic [63:0] rpc;
        logic        gnt, rv;
        logic [31:0] rdata;
        logic        push;
        logic [63:0] ppc;
        logic        ereq;
        logic [63:0] eaddr;
        logic        evalid;
        logic [31:0] einst;
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    vec_t tbl[10];

    function automatic vec_t mkv(logic st, logic rd, logic [63:0] rpc, logic gnt,
                                 logic rv, logic [31:0] rdata, logic push,
                                 logic [63:0] ppc, logic ereq, logic [63:0] eaddr,
                                 logic evalid, logic [31:0] einst);
        vec_t v;
        v.st = st; v.rd = rd; v.rpc = rpc; v.gnt = gnt; v.rv = rv;
        v.rdata = rdata; v.push = push; v.ppc = ppc; v.ereq = ereq;
        v.eaddr = eaddr; v.evalid = evalid; v.einst = einst;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check request side before the edge,
    // IF/ID after the edge, and pop the scoreboard on each fresh load.
    task automatic cyc(input string tag, input vec_t v);
        exp_t e;
        @(negedge clk);
        stall = v.st; redirect = v.rd; redirect_pc = v.rpc;
        imem_gnt = v.gnt; imem_rvalid = v.rv; imem_rdata = v.rdata;
        if (v.push) begin
            e.inst = v.rdata; e.pc = v.ppc;
            q.push_back(e);
        end
        #1;
        chk({tag, " imem_req"}, {63'b0, imem_req}, {63'b0, v.ereq});
        if (v.ereq) chk({tag, " imem_addr"}, imem_addr, v.eaddr);
        @(posedge clk);
        #1;
        chk({tag, " Valid_id"}, {63'b0, Valid_id}, {63'b0, v.evalid});
        chk({tag, " Inst_id"}, {32'b0, Inst_id}, {32'b0, v.einst});
        // IF/ID just loaded (not held by stall, not flushed) with a real instr.
        if (!v.st && !v.rd && Valid_id) begin
            if (q.size() == 0) begin
                tests++; fails++;
                $display("FAIL %s sb_unexpected: got inst %h pc %h expected none", tag, Inst_id, Pc_id);
            end else begin
                e = q.pop_front();
                chk({tag, " sb_inst"}, {32'b0, Inst_id}, {32'b0, e.inst});
                chk({tag, " sb_pc"}, Pc_id, e.pc);
            end
        end
    endtask

    initial begin
        // Zero-wait memory, then a 4-cycle grant gap producing bubbles.
        tbl[0] = mkv(0,0,0, 1,0,0,            0,0,      1,B,       0,N);
        tbl[1] = mkv(0,0,0, 0,1,32'h00500093, 1,B,      0,0,       1,32'h00500093);
        tbl[2] = mkv(0,0,0, 1,0,0,            0,0,      1,B+4,     0,N);
        tbl[3] = mkv(0,0,0, 0,1,32'h00a00113, 1,B+4,    0,0,       1,32'h00a00113);
        tbl[4] = mkv(0,0,0, 0,0,0,            0,0,      1,B+8,     0,N);
        tbl[5] = mkv(0,0,0, 0,0,0,            0,0,      1,B+8,     0,N);
        tbl[6] = mkv(0,0,0, 0,0,0,            0,0,      1,B+8,     0,N);
        tbl[7] = mkv(0,0,0, 0,0,0,            0,0,      1,B+8,     0,N);
        tbl[8] = mkv(0,0,0, 1,0,0,            0,0,      1,B+8,     0,N);
        tbl[9] = mkv(0,0,0, 0,1,32'h00000517, 1,B+8,    0,0,       1,32'h00000517);

        rst_n = 1'b0; stall = 0; redirect = 0; redirect_pc = '0;
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst Valid_id", {63'b0, Valid_id}, 64'd0);
        chk("rst Inst_id", {32'b0, Inst_id}, {32'b0, N});
        chk("rst Pc_id", Pc_id, 64'd0);
        chk("rst imem_req", {63'b0, imem_req}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) cyc($sformatf("tbl%0d", i), tbl[i]);

        // Stall for 3 cycles starting with the response; drains after.
        cyc("stA", mkv(0,0,0, 1,0,0,            0,0,      1,B+12,  0,N));
        cyc("stB", mkv(1,0,0, 0,1,32'h11111113, 1,B+12,   0,0,     0,N));
        cyc("stC", mkv(1,0,0, 0,0,0,            0,0,      0,0,     0,N));
        cyc("stD", mkv(1,0,0, 0,0,0,            0,0,      0,0,     0,N));
        cyc("stE", mkv(0,0,0, 0,0,0,            0,0,      0,0,     1,32'h11111113));

        // Redirect while waiting; the late response must be dropped.
        cyc("rwF", mkv(0,0,0,      1,0,0,            0,0,     1,B+16,  0,N));
        cyc("rwG", mkv(0,1,B+256,  0,0,0,            0,0,     0,0,     0,N));
        cyc("rwH", mkv(0,0,0,      0,0,0,            0,0,     0,0,     0,N));
        cyc("rwI", mkv(0,0,0,      0,1,32'hdeadbeef, 0,0,     0,0,     0,N));
        cyc("rwJ", mkv(0,0,0,      1,0,0,            0,0,     1,B+256, 0,N));
        cyc("rwK", mkv(0,0,0,      0,1,32'h00100093, 1,B+256, 0,0,     1,32'h00100093));

        // Redirect together with stall while buffered: flush, buffer lost.
        cyc("rsL", mkv(0,0,0,      1,0,0,            0,0,     1,B+260, 0,N));
        cyc("rsM", mkv(1,0,0,      0,1,32'h22222213, 0,0,     0,0,     0,N));
        cyc("rsN", mkv(1,1,B+512,  0,0,0,            0,0,     0,0,     0,N));
        cyc("rsO", mkv(0,0,0,      1,0,0,            0,0,     1,B+512, 0,N));
        cyc("rsP", mkv(0,0,0,      0,1,32'h33333313, 1,B+512, 0,0,     1,32'h33333313));

        // Redirect coinciding with the response: dropped, drop not left set.
        cyc("rvQ", mkv(0,0,0,      1,0,0,            0,0,     1,B+516, 0,N));
        cyc("rvR", mkv(0,1,B+768,  0,1,32'h77777713, 0,0,     0,0,     0,N));
        cyc("rvS", mkv(0,0,0,      1,0,0,            0,0,     1,B+768, 0,N));
        cyc("rvT", mkv(0,0,0,      0,1,32'h44444413, 1,B+768, 0,0,     1,32'h44444413));

        // PC wrap at the top of the address space.
        cyc("wr1", mkv(0,1,64'hFFFF_FFFF_FFFF_FFFC, 0,0,0, 0,0, 0,0, 0,N));
        cyc("wr2", mkv(0,0,0, 1,0,0,            0,0,                      1,64'hFFFF_FFFF_FFFF_FFFC, 0,N));
        cyc("wr3", mkv(0,0,0, 0,1,32'h88888813, 1,64'hFFFF_FFFF_FFFF_FFFC, 0,0,  1,32'h88888813));
        cyc("wr4", mkv(0,0,0, 1,0,0,            0,0,                      1,64'd0, 0,N));
        cyc("wr5", mkv(0,0,0, 0,1,32'h99999913, 1,64'd0,                  0,0,  1,32'h99999913));

        // Async reset pulse while waiting, then a stray response.
        cyc("arU", mkv(0,0,0, 1,0,0, 0,0, 1,64'd4, 0,N));
        rst_n = 1'b0;
        #1;
        chk("ar Valid_id", {63'b0, Valid_id}, 64'd0);
        chk("ar Inst_id", {32'b0, Inst_id}, {32'b0, N});
        chk("ar Pc_id", Pc_id, 64'd0);
        chk("ar imem_req", {63'b0, imem_req}, 64'd0);
        #1;
        rst_n = 1'b1;
        cyc("arV", mkv(0,0,0, 0,1,32'h55555513, 0,0, 1,B, 0,N));
        cyc("arW", mkv(0,0,0, 1,0,0,            0,0, 1,B, 0,N));
        cyc("arX", mkv(0,0,0, 0,1,32'h66666613, 1,B, 0,0, 1,32'h66666613));

        chk("sb_left", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Safety net against a hung run.
    initial begin
        #20000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the 5-stage RV64I core. It sits directly upstream of the load-use hazard detector and consumes its `stall` output. It sequences the PC, drives a single-outstanding request/grant/response instruction-memory port, and holds, bubbles or flushes the IF/ID register according to `stall` and the EX-stage `redirect`.

## Interface
Parameters:
- `XLEN`, 64, PC width.
- `RESET_PC`, 64'h8000_0000, first fetch address after reset.

Ports:
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `stall`  input  1  load-use stall from the hazard detector; hold IF/ID.
- `redirect`  input  1  taken branch/jump resolved in EX; flush and refetch.
- `redirect_pc`  input  XLEN  target PC, valid when `redirect`=1.
- `imem_req`  output  1  fetch request.
- `imem_addr`  output  XLEN  fetch address, valid when `imem_req`=1.
- `imem_gnt`  input  1  request accepted this cycle.
- `imem_rvalid`  input  1  response data valid.
- `imem_rdata`  input  32  fetched instruction.
- `Inst_id`  output  32  IF/ID instruction.
- `Pc_id`  output  XLEN  IF/ID PC.
- `Valid_id`  output  1  IF/ID holds a real instruction. 0 means bubble.

## Operation
- Registers:
  - `pc`: next address to request.
  - `pc_inflight`: address of the outstanding request.
  - `buf_inst` and `buf_pc`: single-entry skid buffer.
  - `drop`: discard the next response.
  - FSM state.
- Priority for the IF/ID register is redirect > stall > normal.
- FSM states REQ, WAIT, BUF.
  - **REQ**
    - `imem_req`=1 and `imem_addr`=`pc`, unless `redirect`=1. In that case `imem_req`=0 and `pc`<=`redirect_pc`, and the FSM stays in REQ.
    - On `imem_gnt`: `pc_inflight`<=`pc`, `pc`<=`pc`+4 (mod 2^XLEN), go to WAIT.
    - Requests are issued regardless of `stall`.
  - **WAIT**
    - `imem_req`=0.
    - On `imem_rvalid`:
      - If `drop`=1 or `redirect`=1: discard the response, clear `drop`, go to REQ.
      - Else if `stall`=1: capture into `buf_inst`/`buf_pc`, go to BUF.
      - Else: load IF/ID with `imem_rdata`/`pc_inflight`, `Valid_id`<=1, go to REQ.
    - `redirect` without `imem_rvalid`: `pc`<=`redirect_pc`, `drop`<=1.
  - **BUF**
    - `imem_req`=0.
    - `redirect`: discard the buffer, `pc`<=`redirect_pc`, go to REQ.
    - Else if `stall`=0: load IF/ID from the buffer, `Valid_id`<=1, go to REQ.
- IF/ID register per cycle:
  - `redirect`=1: `Valid_id`<=0 (flush). `Inst_id`/`Pc_id` are don't-care but are set to NOP/0.
  - Else `stall`=1: all three hold.
  - Else, if a new instruction is delivered (WAIT response or BUF drain): load it.
  - Otherwise `Valid_id`<=0, `Inst_id`<=32'h0000_0013 (NOP). This is a bubble.
- `imem_rdata` is only sampled when `imem_rvalid`=1 in WAIT. `imem_rvalid` in REQ or BUF is a protocol error and is ignored.
- `imem_addr` stays stable while `imem_req`=1 and no grant has arrived. The only exception is a `redirect`, which deasserts `imem_req` for that cycle.

## Timing
- Reset (asynchronous, while `rst_n`=0):
  - `pc`=`RESET_PC`, state REQ, `drop`=0.
  - `Valid_id`=0, `Inst_id`=32'h0000_0013, `Pc_id`=0.
  - `imem_req` is forced to 0 while `rst_n`=0.
- First request: `imem_req`=1 in the first cycle after `rst_n` deasserts.
- Latency: grant in cycle N, earliest `imem_rvalid` in N+1, `Valid_id`=1 visible in N+2. A zero-wait memory sustains one instruction per 2 cycles.
- Reset asserted mid-operation abandons any outstanding request. A late `imem_rvalid` after reset is ignored because the FSM is in REQ.
- Simultaneous events:
  - `redirect` with `stall`: the flush wins.
  - `redirect` with `imem_gnt` in REQ: cannot happen, because `imem_req` is 0.
  - `redirect` with `imem_rvalid`: the response is dropped and `drop` is not set.
- PC wrap: `pc`=2^XLEN−4 increments to 0.

## Test plan
- **Reset, then zero-wait memory:** `gnt` in the same cycle as `req`, `rvalid` one cycle later with rdata 0x00500093. Required: `imem_addr`=0x8000_0000, then 0x8000_0004. `Pc_id`=0x8000_0000, `Inst_id`=0x00500093, `Valid_id`=1 two cycles after the grant.
- **Stall during the response:** `stall`=1 for 3 cycles, starting the cycle `rvalid` arrives. Required: IF/ID holds its previous value for all 3 cycles. The buffered instruction appears the cycle after `stall` drops. No instruction is lost or duplicated.
- **Redirect in WAIT:** `redirect`=1 with `redirect_pc`=0x8000_0100 while waiting, and `rvalid` 2 cycles later. Required: the response is discarded and `Valid_id`=0. The next request has `imem_addr`=0x8000_0100.
- **Redirect with stall in the same cycle:** Required: `Valid_id`=0 next cycle (flush wins) and the BUF contents are discarded.
- **Async reset mid-WAIT:** `rst_n` pulsed low, then a stray `rvalid` arrives. Required: all outputs go to reset values immediately. The stray response is ignored and fetch restarts at `RESET_PC`.
- **Bubble insertion:** grant delayed 4 cycles with `stall`=0. Required: `Valid_id`=0 and `Inst_id`=0x00000013 during the gap.
